// File: rtl/mips_alu_if.sv
// Operand/select/result bundle for mips_alu.
// The driver of the operands uses the master modport; the ALU uses the slave modport.
interface mips_alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic [2:0]       alu_control;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (
      output alu_control, src1, src2,
      input  result, zero
   );

   modport slave (
      input  alu_control, src1, src2,
      output result, zero
   );
endinterface

// File: rtl/mips_alu.sv
// Single-cycle-latency MIPS ALU with registered result and equality flag.
// The equality flag always comes from src1 - src2, whatever operation is selected.
module mips_alu #(
   parameter int unsigned WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   mips_alu_if.slave  alu
);

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b110,
      OP_SLT = 3'b111
   } alu_op_e;

   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] diff;
   logic             slt;

   always_comb begin
      diff     = alu.src1 - alu.src2;
      slt      = $signed(alu.src1) < $signed(alu.src2);
      zero_d   = (diff == '0);
      result_d = '0;
      case (alu.alu_control)
         OP_AND:  result_d = alu.src1 & alu.src2;
         OP_OR:   result_d = alu.src1 | alu.src2;
         OP_ADD:  result_d = alu.src1 + alu.src2;
         OP_SUB:  result_d = diff;
         OP_SLT:  result_d = WIDTH'(slt);
         default: result_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign alu.result = result_q;
   assign alu.zero   = zero_q;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: expected values are queued as stimulus is applied
// and compared one clock later, after the edge that should have produced them.
module tb_mips_alu;
   localparam int unsigned W = 32;

   typedef struct packed {
      logic [W-1:0] r;
      logic         z;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mips_alu_if #(.WIDTH(W)) bus ();
   mips_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .alu(bus));

   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.z = (a == b);
      case (op)
         3'b000:  e.r = a & b;
         3'b001:  e.r = a | b;
         3'b010:  e.r = a + b;
         3'b110:  e.r = a - b;
         3'b111:  e.r = (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
         default: e.r = '0;
      endcase
      return e;
   endfunction

   // Apply one cycle of stimulus, queue its expectation, and step to just after the edge.
   task automatic drive(input logic r_in, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ez);
      exp_t e;
      rst             = r_in;
      bus.alu_control = op;
      bus.src1        = a;
      bus.src2        = b;
      e.r = er;
      e.z = ez;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'b010, 32'd7, 32'd7, 32'd0, 1'b0);
         e = exp_q.pop_front();
         n_chk++;
         if (bus.result !== e.r || bus.zero !== e.z) begin
            n_fail++;
            $display("FAIL reset[%0d]: result=%h zero=%b expected result=%h zero=%b", i, bus.result, bus.zero, e.r, e.z);
         end
      end
   endtask

   task automatic test_add;
      exp_t e;
      drive(1'b0, 3'b010, 32'd17, 32'd10, 32'd27, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (bus.result !== e.r || bus.zero !== e.z) begin
         n_fail++;
         $display("FAIL add_17_10: result=%h zero=%b expected result=%h zero=%b", bus.result, bus.zero, e.r, e.z);
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0]   ops [5] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b101};
      logic [W-1:0] res [5] = '{32'd7, 32'd0, 32'd27, 32'd0, 32'd0};
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, ops[i], 32'd17, 32'd10, res[i], 1'b0);
         e = exp_q.pop_front();
         n_chk++;
         if (bus.result !== e.r || bus.zero !== e.z) begin
            n_fail++;
            $display("FAIL b2b[%0d] op=%b: result=%h zero=%b expected result=%h zero=%b", i, ops[i], bus.result, bus.zero, e.r, e.z);
         end
      end
   endtask

   task automatic test_equal;
      logic [2:0]   ops [2] = '{3'b111, 3'b010};
      logic [W-1:0] res [2] = '{32'd0, 32'd20};
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, ops[i], 32'd10, 32'd10, res[i], 1'b1);
         e = exp_q.pop_front();
         n_chk++;
         if (bus.result !== e.r || bus.zero !== e.z) begin
            n_fail++;
            $display("FAIL equal[%0d] op=%b: result=%h zero=%b expected result=%h zero=%b", i, ops[i], bus.result, bus.zero, e.r, e.z);
         end
      end
   endtask

   task automatic test_boundaries;
      logic [2:0]   ops [8] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b010, 3'b110, 3'b011, 3'b100};
      logic [W-1:0] a   [8] = '{32'h80000000, 32'h80000000, 32'h12345678, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h00000000, 32'hF0F0F0F0, 32'hA5A5A5A5};
      logic [W-1:0] b   [8] = '{32'h7FFFFFFF, 32'h00000001, 32'h12345678, 32'h00000000,
                                32'h00000001, 32'h00000001, 32'h0F0F0F0F, 32'hA5A5A5A5};
      logic [W-1:0] res [8] = '{32'd1, 32'd1, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
      logic         zr  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, ops[i], a[i], b[i], res[i], zr[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (bus.result !== e.r || bus.zero !== e.z) begin
            n_fail++;
            $display("FAIL boundary[%0d] op=%b a=%h b=%h: result=%h zero=%b expected result=%h zero=%b",
                     i, ops[i], a[i], b[i], bus.result, bus.zero, e.r, e.z);
         end
      end
      drive(1'b0, 3'b101, 32'hFFFFFFFF, 32'h00000001, 32'd0, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (bus.result !== e.r || bus.zero !== e.z) begin
         n_fail++;
         $display("FAIL unused_101: result=%h zero=%b expected result=%h zero=%b", bus.result, bus.zero, e.r, e.z);
      end
   endtask

   task automatic test_reset_midstream;
      logic         rs  [3] = '{1'b0, 1'b1, 1'b0};
      logic [W-1:0] a   [3] = '{32'd3, 32'd5, 32'd5};
      logic [W-1:0] res [3] = '{32'd7, 32'd0, 32'd10};
      logic         zr  [3] = '{1'b0, 1'b0, 1'b1};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(rs[i], 3'b010, a[i], (i == 0) ? 32'd4 : 32'd5, res[i], zr[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (bus.result !== e.r || bus.zero !== e.z) begin
            n_fail++;
            $display("FAIL rst_mid[%0d] rst=%b: result=%h zero=%b expected result=%h zero=%b", i, rs[i], bus.result, bus.zero, e.r, e.z);
         end
      end
   endtask

   task automatic test_random;
      logic [2:0] codes [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      logic [2:0]   op;
      logic [W-1:0] a, b;
      exp_t m, e;
      for (int i = 0; i < 48; i++) begin
         op = codes[$urandom_range(0, 7)];
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         m  = model(op, a, b);
         drive(1'b0, op, a, b, m.r, m.z);
         e = exp_q.pop_front();
         n_chk++;
         if (bus.result !== e.r || bus.zero !== e.z) begin
            n_fail++;
            $display("FAIL random[%0d] op=%b a=%h b=%h: result=%h zero=%b expected result=%h zero=%b",
                     i, op, a, b, bus.result, bus.zero, e.r, e.z);
         end
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.alu_control = 3'b000;
      bus.src1        = '0;
      bus.src2        = '0;
      test_reset();
      test_add();
      test_back_to_back();
      test_equal();
      test_boundaries();
      test_reset_midstream();
      test_random();
      if (exp_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded 100000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mips_alu.md
MIPS_ALU -- requirements
Module: mips_alu

Interface
REQ-001 Parameter WIDTH, default 32, data path width of operands and result; all widths below are stated for the default.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 alu_control  input  3  operation select.
REQ-005 src1  input  32  operand A.
REQ-006 src2  input  32  operand B.
REQ-007 result  output  32  registered operation result.
REQ-008 zero  output  1  registered equality flag, 1 when src1 == src2.

Function
REQ-009 The block SHALL sample alu_control, src1 and src2 on every rising clk edge and present the corresponding result and zero one cycle later (latency 1, throughput 1 per cycle).
REQ-010 Outputs SHALL hold their value between edges; there is no handshake or enable.
REQ-011 alu_control 3'b000 SHALL produce result = src1 AND src2, bitwise.
REQ-012 alu_control 3'b001 SHALL produce result = src1 OR src2, bitwise.
REQ-013 alu_control 3'b010 SHALL produce result = src1 + src2, modulo 2^32; carry-out discarded, no overflow flag.
REQ-014 alu_control 3'b110 SHALL produce result = src1 - src2, modulo 2^32; borrow discarded.
REQ-015 alu_control 3'b111 SHALL produce result = 32'd1 when src1 < src2 as signed two's-complement values, else 32'd0.
REQ-016 Unused codes 3'b011, 3'b100, 3'b101 SHALL produce result = 32'd0; no X is ever driven.
REQ-017 zero SHALL equal 1 exactly when (src1 - src2) mod 2^32 == 0, i.e. src1 == src2, for every alu_control value, independent of result.
REQ-018 SLT boundaries: 0x80000000 < 0x7FFFFFFF gives 1; equal operands give 0; 0xFFFFFFFF (-1) < 0 gives 1.
REQ-019 Arithmetic boundaries: 0xFFFFFFFF + 1 gives 0; 0 - 1 gives 0xFFFFFFFF.
REQ-020 Inputs that are X or Z are out of contract; the behaviour for them is not specified.

Reset
REQ-021 While rst is high at a rising clk edge, result SHALL become 32'd0 and zero SHALL become 0; inputs are ignored on that edge.
REQ-022 On the first rising edge with rst low, the block SHALL resume normal operation per REQ-009 with no extra latency.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight operation; the next edge with rst low loads a fresh result.

Verification
REQ-024 src1=17, src2=10, alu_control=010 -> result=27, zero=0 one cycle later.
REQ-025 Same operands, alu_control sequenced 110, 000, 001, 111, 101 on consecutive cycles -> result 7, 0, 27, 0, 0 with zero=0 throughout, each one cycle after its select.
REQ-026 src1=10, src2=10, alu_control=111 -> result=0, zero=1; then alu_control=010 -> result=20, zero=1.
REQ-027 Signed and wrap checks -> SLT 0x80000000 vs 0x00000001 gives 1; ADD 0xFFFFFFFF + 1 gives 0 with zero=0; SUB 0 - 1 gives 0xFFFFFFFF.
REQ-028 Reset checks -> rst high for one cycle mid-stream with ADD 5+5 applied gives result=0, zero=0 on that edge; rst low with ADD 5+5 still applied gives result=10 and zero=1 on the next edge.
